// File: rtl/mpi_send_ctrl_if.sv
// rtl/mpi_send_ctrl_if.sv - signal bundle for mpi_send_ctrl: command, payload, outbound/inbound stream, response
interface mpi_send_ctrl_if;
   // Send command
   logic        cmd_valid;
   logic        cmd_ready;
   logic [15:0] cmd_dst_rank;
   logic [7:0]  cmd_src_rank;
   logic [15:0] cmd_size;
   logic [7:0]  cmd_tag;
   // User payload
   logic [63:0] pay_data;
   logic [7:0]  pay_keep;
   logic        pay_last;
   logic        pay_valid;
   logic        pay_ready;
   // MPI stream towards the network
   logic [63:0] stream_out_data;
   logic [7:0]  stream_out_keep;
   logic        stream_out_last;
   logic        stream_out_valid;
   logic        stream_out_ready;
   // Control packets from the network
   logic [63:0] stream_in_data;
   logic [7:0]  stream_in_keep;
   logic        stream_in_last;
   logic        stream_in_valid;
   logic        stream_in_ready;
   // Completion
   logic        resp_valid;
   logic        resp_error;

   modport slave (
      input  cmd_valid, cmd_dst_rank, cmd_src_rank, cmd_size, cmd_tag,
      output cmd_ready,
      input  pay_data, pay_keep, pay_last, pay_valid,
      output pay_ready,
      output stream_out_data, stream_out_keep, stream_out_last, stream_out_valid,
      input  stream_out_ready,
      input  stream_in_data, stream_in_keep, stream_in_last, stream_in_valid,
      output stream_in_ready,
      output resp_valid, resp_error
   );

   modport master (
      output cmd_valid, cmd_dst_rank, cmd_src_rank, cmd_size, cmd_tag,
      input  cmd_ready,
      output pay_data, pay_keep, pay_last, pay_valid,
      input  pay_ready,
      input  stream_out_data, stream_out_keep, stream_out_last, stream_out_valid,
      output stream_out_ready,
      output stream_in_data, stream_in_keep, stream_in_last, stream_in_valid,
      input  stream_in_ready,
      input  resp_valid, resp_error
   );
endinterface

// File: rtl/mpi_send_ctrl.sv
// rtl/mpi_send_ctrl.sv - MPI rendezvous send sequencer; optional wait timeout enabled by MPI_SEND_TIMEOUT_EN
module mpi_send_ctrl #(
   parameter int unsigned GAP_CYCLES     = 10,
   parameter int unsigned TIMEOUT_CYCLES = 65535
) (
   input  logic           clk,
   input  logic           rst,
   mpi_send_ctrl_if.slave bus
);

   typedef enum logic [3:0] {
      S_IDLE,
      S_ENV_HDR,
      S_ENV_PAD,
      S_WAIT_CTS,
      S_GAP,
      S_DATA_HDR,
      S_DATA_PAY,
      S_WAIT_DONE,
      S_RESP
   } state_t;

   localparam logic [7:0] TYPE_SYNC_ENV = 8'd0;
   localparam logic [7:0] TYPE_CLR2SND  = 8'd1;
   localparam logic [7:0] TYPE_DATA     = 8'd2;
   localparam logic [7:0] TYPE_DONE     = 8'd5;

   state_t      r_state;
   state_t      w_state_nxt;

   logic [15:0] r_dst;
   logic [7:0]  r_src;
   logic [15:0] r_size;
   logic [7:0]  r_tag;

   logic [63:0] r_out_data;
   logic [7:0]  r_out_keep;
   logic        r_out_last;
   logic        r_out_valid;

   logic        r_sof;
   logic [31:0] r_gap_cnt;
   logic        r_resp_err;

   logic        w_out_free;
   logic        w_load;
   logic [63:0] w_load_data;
   logic [7:0]  w_load_keep;
   logic        w_load_last;
   logic        w_pay_ready;
   logic        w_err_nxt;
   logic        w_first_beat;
   logic        w_cts_match;
   logic        w_done_match;
   logic        w_gap_done;
   logic        w_zero_len;
   logic        w_timeout;
   logic        w_unused_in;

   function automatic logic [63:0] f_hdr(input logic [7:0] typ, input logic [7:0] tag,
                                         input logic [15:0] size, input logic [7:0] src,
                                         input logic [15:0] dst);
      return {8'd1, tag, size, typ, src, dst};
   endfunction

   // The output register may take a new beat once the current one is gone
   assign w_out_free   = !r_out_valid || bus.stream_out_ready;
   assign w_zero_len   = (r_size == 16'd0);
   assign w_gap_done   = ((r_gap_cnt + 32'd1) >= GAP_CYCLES);

   // Only the first beat of an inbound packet carries a header worth matching
   assign w_first_beat = bus.stream_in_valid && r_sof;
   assign w_cts_match  = w_first_beat
                         && (bus.stream_in_data[31:24] == TYPE_CLR2SND)
                         && (bus.stream_in_data[23:16] == r_dst[7:0])
                         && (bus.stream_in_data[7:0]   == r_src);
   assign w_done_match = w_first_beat
                         && (bus.stream_in_data[31:24] == TYPE_DONE)
                         && (bus.stream_in_data[23:16] == r_dst[7:0])
                         && (bus.stream_in_data[15:0]  == {8'd0, r_src});

   // Upper header bits and keep of inbound packets carry nothing we check
   assign w_unused_in  = ^{bus.stream_in_data[63:32], bus.stream_in_keep};

`ifdef MPI_SEND_TIMEOUT_EN
   logic [15:0] r_to_cnt;

   assign w_timeout = (r_to_cnt == 16'(TIMEOUT_CYCLES));

   // Wait watchdog: restarts whenever the FSM is outside WAIT_CTS/WAIT_DONE
   always_ff @(posedge clk) begin
      if (rst || !((r_state == S_WAIT_CTS) || (r_state == S_WAIT_DONE))) begin
         r_to_cnt <= 16'd0;
      end else begin
         r_to_cnt <= r_to_cnt + 16'd1;
      end
   end
`else
   logic w_unused_cfg;

   assign w_timeout    = 1'b0;
   assign w_unused_cfg = (TIMEOUT_CYCLES == 32'd0);
`endif

   // Next state, beat to load into the output register and payload ready
   always_comb begin
      w_state_nxt = r_state;
      w_load      = 1'b0;
      w_load_data = 64'd0;
      w_load_keep = 8'd0;
      w_load_last = 1'b0;
      w_pay_ready = 1'b0;
      w_err_nxt   = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (bus.cmd_valid) begin
               w_state_nxt = S_ENV_HDR;
            end
         end
         S_ENV_HDR: begin
            if (w_out_free) begin
               w_load      = 1'b1;
               w_load_data = f_hdr(TYPE_SYNC_ENV, r_tag, r_size, r_src, r_dst);
               w_load_keep = 8'hff;
               w_state_nxt = S_ENV_PAD;
            end
         end
         S_ENV_PAD: begin
            if (w_out_free) begin
               w_load      = 1'b1;
               w_load_keep = 8'hff;
               w_load_last = 1'b1;
               w_state_nxt = S_WAIT_CTS;
            end
         end
         S_WAIT_CTS: begin
            // A match in the expiry cycle wins over the timeout
            if (w_cts_match) begin
               w_state_nxt = S_GAP;
            end else if (w_timeout) begin
               w_state_nxt = S_RESP;
               w_err_nxt   = 1'b1;
            end
         end
         S_GAP: begin
            if (w_gap_done) begin
               w_state_nxt = S_DATA_HDR;
            end
         end
         S_DATA_HDR: begin
            if (w_out_free) begin
               w_load      = 1'b1;
               w_load_data = f_hdr(TYPE_DATA, r_tag, r_size, r_src, r_dst);
               w_load_keep = 8'hff;
               w_state_nxt = S_DATA_PAY;
            end
         end
         S_DATA_PAY: begin
            if (w_zero_len) begin
               // Empty message still needs one closing beat; payload is untouched
               if (w_out_free) begin
                  w_load      = 1'b1;
                  w_load_keep = 8'hff;
                  w_load_last = 1'b1;
                  w_state_nxt = S_WAIT_DONE;
               end
            end else begin
               w_pay_ready = w_out_free;
               if (w_out_free && bus.pay_valid) begin
                  w_load      = 1'b1;
                  w_load_data = bus.pay_data;
                  w_load_keep = bus.pay_keep;
                  w_load_last = bus.pay_last;
                  if (bus.pay_last) begin
                     w_state_nxt = S_WAIT_DONE;
                  end
               end
            end
         end
         S_WAIT_DONE: begin
            if (w_done_match) begin
               w_state_nxt = S_RESP;
            end else if (w_timeout) begin
               w_state_nxt = S_RESP;
               w_err_nxt   = 1'b1;
            end
         end
         S_RESP: begin
            w_state_nxt = S_IDLE;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // FSM state register
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Command latch, gap counter and completion status
   always_ff @(posedge clk) begin
      if (rst) begin
         r_dst      <= 16'd0;
         r_src      <= 8'd0;
         r_size     <= 16'd0;
         r_tag      <= 8'd0;
         r_gap_cnt  <= 32'd0;
         r_resp_err <= 1'b0;
      end else begin
         if ((r_state == S_IDLE) && bus.cmd_valid) begin
            r_dst  <= bus.cmd_dst_rank;
            r_src  <= bus.cmd_src_rank;
            r_size <= bus.cmd_size;
            r_tag  <= bus.cmd_tag;
         end
         if (r_state == S_GAP) begin
            r_gap_cnt <= r_gap_cnt + 32'd1;
         end else begin
            r_gap_cnt <= 32'd0;
         end
         r_resp_err <= w_err_nxt;
      end
   end

   // Registered outbound beat, held until the consumer takes it
   always_ff @(posedge clk) begin
      if (rst) begin
         r_out_valid <= 1'b0;
         r_out_data  <= 64'd0;
         r_out_keep  <= 8'd0;
         r_out_last  <= 1'b0;
      end else if (w_out_free) begin
         r_out_valid <= w_load;
         if (w_load) begin
            r_out_data <= w_load_data;
            r_out_keep <= w_load_keep;
            r_out_last <= w_load_last;
         end
      end
   end

   // Inbound start-of-frame tracker
   always_ff @(posedge clk) begin
      if (rst) begin
         r_sof <= 1'b1;
      end else if (bus.stream_in_valid) begin
         r_sof <= bus.stream_in_last;
      end
   end

   assign bus.cmd_ready        = (r_state == S_IDLE);
   assign bus.pay_ready        = w_pay_ready;
   assign bus.stream_out_data  = r_out_data;
   assign bus.stream_out_keep  = r_out_keep;
   assign bus.stream_out_last  = r_out_last;
   assign bus.stream_out_valid = r_out_valid;
   assign bus.stream_in_ready  = 1'b1;
   assign bus.resp_valid       = (r_state == S_RESP);
   assign bus.resp_error       = r_resp_err;

endmodule
